snoop_bus_arbiter: RTL and testbench
====================================

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, width of the block address broadcast on the snoop bus.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 15, SNOOP-state cycle limit (used only with SNOOP_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  4  per-core bus request from cache controllers 0..3.
REQ-006 SHALL have port req_rd_wr  input  4  per-core operation; 1=write, 0=read.
REQ-007 SHALL have port req_addr  input  4*ADDR_W  packed per-core address, core n at bits [n*ADDR_W +: ADDR_W].
REQ-008 SHALL have port snoop_ack  input  4  per-core snoop-complete strobe.
REQ-009 SHALL have port snoop_hit  input  4  per-core "line present", valid with snoop_ack.
REQ-010 SHALL have port snoop_dirty  input  4  per-core "line Modified", valid with snoop_ack.
REQ-011 SHALL have port gnt  output  4  one-hot grant, zero when idle.
REQ-012 SHALL have port bus_valid  output  1  snoop broadcast valid.
REQ-013 SHALL have port bus_proc_id  output  2  granted core index.
REQ-014 SHALL have port bus_rd_wr  output  1  granted core's operation.
REQ-015 SHALL have port bus_addr  output  ADDR_W  granted core's address.
REQ-016 SHALL have port done  output  1  one-cycle transaction-complete pulse.
REQ-017 SHALL have ports resp_shared and resp_dirty  output  1 each  OR of collected snoop_hit / snoop_dirty, valid with done.
REQ-018 SHALL have port timeout_err  output  1  present only with SNOOP_TIMEOUT_EN.

Function
REQ-019 SHALL implement FSM IDLE -> SNOOP -> DONE -> IDLE.
REQ-020 In IDLE with req!=0, SHALL pick winner round-robin starting at (last_winner+1) mod 4, and enter SNOOP next edge.
REQ-021 In SNOOP, gnt, bus_valid=1, bus_proc_id, bus_rd_wr, bus_addr SHALL be registered copies captured at the IDLE->SNOOP edge and held stable.
REQ-022 SHALL keep a sticky 4-bit ack mask, cleared on SNOOP entry; winner's own bit preset to 1; its snoop_ack ignored.
REQ-023 SHALL accumulate resp_shared/resp_dirty as OR of snoop_hit/snoop_dirty of non-winner cores in cycles their snoop_ack=1.
REQ-024 SHALL go SNOOP->DONE on the edge where the mask (including same-cycle acks) becomes all ones.
REQ-025 In DONE, done=1 for exactly one cycle, gnt held, bus_valid=0; last_winner updated; next state IDLE.
REQ-026 Minimum latency: req sampled edge 0 -> bus_valid cycle 1 -> all acks cycle 1 -> done cycle 2 -> new grant earliest cycle 4.
REQ-027 Winner deasserting req during SNOOP SHALL NOT abort the transaction.
REQ-028 Repeated snoop_ack from one core SHALL be counted once.
REQ-029 gnt SHALL never have more than one bit set.

Reset
REQ-030 On rst_n=0, asynchronously: state=IDLE, gnt=0, bus_valid=0, bus_proc_id=0, bus_rd_wr=0, bus_addr=0, done=0, resp_shared=0, resp_dirty=0, timeout_err=0, mask=0, last_winner=3 (core 0 first).
REQ-031 Reset mid-SNOOP SHALL abandon the transaction with no done pulse.

Configuration
REQ-032 With SNOOP_TIMEOUT_EN defined, SHALL count SNOOP cycles; at TIMEOUT_CYC without full mask, SHALL go to DONE with timeout_err=1 for that DONE cycle only.
REQ-033 Without SNOOP_TIMEOUT_EN, SHALL have no counter or timeout_err port; SNOOP waits indefinitely.

Structure
REQ-034 SHALL place the FSM state enum, NUM_CORES=4 and core-ID type in shared package cache_pkg.
REQ-035 SHALL implement winner selection as sub-module rr_arbiter4 (req, last_winner -> one-hot, index).

Verification
REQ-036 Reset, then req=4'b0010, write, addr 0x3C; acks from 0,2,3 in cycle 1 -> gnt=0010, bus_proc_id=1, bus_addr=0x3C in cycle 1, done cycle 2.
REQ-037 req=4'b1111 held continuously -> grants in order 0,1,2,3,0.
REQ-038 Core 2 requests, core 0 hit+dirty, acks staggered over cycles 1,3,5 -> done cycle 6, resp_shared=1, resp_dirty=1.
REQ-039 Core 3 acks twice, core 1 never acks -> no done; with SNOOP_TIMEOUT_EN, done and timeout_err at SNOOP cycle 15.
REQ-040 rst_n asserted mid-SNOOP -> all outputs zero immediately; next grant goes to core 0.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared core count, core-ID type and snoop FSM state encoding
package cache_pkg;

    localparam int NUM_CORES = 4;

    typedef logic [1:0] core_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One-hot grant vector for a core index
    function automatic logic [NUM_CORES-1:0] id_to_onehot(input core_id_t id);
        return NUM_CORES'(1) << id;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin pick, search starts one past last_winner
module rr_arbiter4
    import cache_pkg::*;
(
    input  logic [NUM_CORES-1:0] req,
    input  core_id_t             last_winner,
    output logic [NUM_CORES-1:0] gnt_onehot,
    output core_id_t             idx,
    output logic                 any
);

    // Scan cores (last_winner+1 .. last_winner+4) mod 4; 2-bit adds wrap naturally
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            if (!any && req[last_winner + core_id_t'(i)]) begin
                idx = last_winner + core_id_t'(i);
                any = 1'b1;
            end
        end
        gnt_onehot = any ? id_to_onehot(idx) : '0;
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin snoop bus arbiter with ack collection.
// Optional SNOOP_TIMEOUT_EN: bound the SNOOP phase to TIMEOUT_CYC cycles
// and flag timeout_err on the resulting DONE cycle.
module snoop_bus_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          req_rd_wr,
    input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CORES-1:0]          snoop_ack,
    input  logic [NUM_CORES-1:0]          snoop_hit,
    input  logic [NUM_CORES-1:0]          snoop_dirty,
    output logic [NUM_CORES-1:0]          gnt,
    output logic                          bus_valid,
    output core_id_t                      bus_proc_id,
    output logic                          bus_rd_wr,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic                          done,
    output logic                          resp_shared,
    output logic                          resp_dirty
`ifdef SNOOP_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    state_t                 state;
    core_id_t               last_winner;
    logic [NUM_CORES-1:0]   mask;
    logic [NUM_CORES-1:0]   w_onehot;
    core_id_t               w_idx;
    logic                   w_any;
    logic [NUM_CORES-1:0]   ack_eff;
    logic                   mask_full;
    logic                   timeout_hit;

    rr_arbiter4 u_rr (
        .req         (req),
        .last_winner (last_winner),
        .gnt_onehot  (w_onehot),
        .idx         (w_idx),
        .any         (w_any)
    );

    // Winner's own ack never contributes; mask already has its bit preset
    assign ack_eff   = snoop_ack & ~gnt;
    assign mask_full = &(mask | snoop_ack);

`ifdef SNOOP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] snoop_cnt;

    assign timeout_hit = (snoop_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // SNOOP cycle counter and one-cycle timeout flag for the forced DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snoop_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            snoop_cnt   <= (state == SNOOP) ? snoop_cnt + CNT_W'(1) : '0;
            timeout_err <= (state == SNOOP) && !mask_full && timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Transaction FSM: capture winner in IDLE, collect acks in SNOOP, pulse done in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            bus_valid   <= 1'b0;
            bus_proc_id <= '0;
            bus_rd_wr   <= 1'b0;
            bus_addr    <= '0;
            done        <= 1'b0;
            resp_shared <= 1'b0;
            resp_dirty  <= 1'b0;
            mask        <= '0;
            last_winner <= core_id_t'(NUM_CORES - 1);
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_any) begin
                        state       <= SNOOP;
                        gnt         <= w_onehot;
                        bus_valid   <= 1'b1;
                        bus_proc_id <= w_idx;
                        bus_rd_wr   <= req_rd_wr[w_idx];
                        bus_addr    <= req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
                        mask        <= w_onehot;
                        resp_shared <= 1'b0;
                        resp_dirty  <= 1'b0;
                    end
                end
                SNOOP: begin
                    mask        <= mask | snoop_ack;
                    resp_shared <= resp_shared | |(snoop_hit & ack_eff);
                    resp_dirty  <= resp_dirty | |(snoop_dirty & ack_eff);
                    if (mask_full || timeout_hit) begin
                        state     <= DONE;
                        bus_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    gnt         <= '0;
                    mask        <= '0;
                    last_winner <= bus_proc_id;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Structural invariants of the grant and handshake outputs
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_done_excl:   assert property (@(posedge clk) disable iff (!rst_n) !(done && bus_valid));
    a_timeout_cfg: assert property (@(posedge clk) disable iff (!rst_n) TIMEOUT_CYC > 0);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: directed + random stimulus against a transaction-level model
module tb_snoop_bus_arbiter;

    localparam int AW = 8;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        req = '0, req_rd_wr = '0, snoop_ack = '0, snoop_hit = '0, snoop_dirty = '0;
    logic [4*AW-1:0]   req_addr = '0;
    logic [3:0]        gnt;
    logic              bus_valid, bus_rd_wr, done, resp_shared, resp_dirty;
    logic [1:0]        bus_proc_id;
    logic [AW-1:0]     bus_addr;
`ifdef SNOOP_TIMEOUT_EN
    logic              timeout_err;
`endif

    snoop_bus_arbiter #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_rd_wr   (req_rd_wr),
        .req_addr    (req_addr),
        .snoop_ack   (snoop_ack),
        .snoop_hit   (snoop_hit),
        .snoop_dirty (snoop_dirty),
        .gnt         (gnt),
        .bus_valid   (bus_valid),
        .bus_proc_id (bus_proc_id),
        .bus_rd_wr   (bus_rd_wr),
        .bus_addr    (bus_addr),
        .done        (done),
        .resp_shared (resp_shared),
        .resp_dirty  (resp_dirty)
`ifdef SNOOP_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Transaction-level model: one open transaction at a time
    int            m_last;
    bit            m_busy, m_fin, m_terr;
    int            m_w, m_cyc;
    bit            m_rw, m_sh, m_dt;
    logic [AW-1:0] m_addr;
    bit            m_got[4];
    int            seen[$];
    logic          prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_last = 3;
        m_busy = 0;
        m_fin  = 0;
        m_terr = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] rw, input logic [4*AW-1:0] ad,
                              input logic [3:0] k, input logic [3:0] h, input logic [3:0] d);
        if (m_fin) begin
            m_fin  = 0;
            m_busy = 0;
            m_terr = 0;
            m_last = m_w;
        end else if (m_busy) begin
            m_cyc++;
            for (int c = 0; c < 4; c++) begin
                if (c != m_w && k[c]) begin
                    m_got[c] = 1;
                    m_sh = m_sh | h[c];
                    m_dt = m_dt | d[c];
                end
            end
            if (m_got[0] && m_got[1] && m_got[2] && m_got[3]) m_fin = 1;
`ifdef SNOOP_TIMEOUT_EN
            else if (m_cyc == TO) begin
                m_fin  = 1;
                m_terr = 1;
            end
`endif
        end else if (r != 4'b0) begin
            for (int o = 1; o <= 4; o++) begin
                int c;
                c = (m_last + o) % 4;
                if (r[c]) begin
                    m_w = c;
                    break;
                end
            end
            m_busy = 1;
            for (int c = 0; c < 4; c++) m_got[c] = (c == m_w);
            m_sh   = 0;
            m_dt   = 0;
            m_rw   = rw[m_w];
            m_addr = ad[m_w*AW +: AW];
            m_cyc  = 0;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eg;
        eg = m_busy ? 4'(1 << m_w) : 4'b0;
        check("gnt", gnt, eg);
        check("bus_valid", bus_valid, m_busy && !m_fin);
        check("done", done, m_fin);
        if (m_busy && !m_fin) begin
            check("bus_proc_id", bus_proc_id, m_w);
            check("bus_rd_wr", bus_rd_wr, m_rw);
            check("bus_addr", bus_addr, m_addr);
        end
        if (m_fin) begin
            check("resp_shared", resp_shared, m_sh);
            check("resp_dirty", resp_dirty, m_dt);
        end
`ifdef SNOOP_TIMEOUT_EN
        check("timeout_err", timeout_err, m_terr);
`endif
        if (bus_valid && !prev_valid) seen.push_back(int'(bus_proc_id));
        prev_valid = bus_valid;
    endtask

    task automatic cyc(input logic [3:0] r, input logic [3:0] rw, input logic [4*AW-1:0] ad,
                       input logic [3:0] k, input logic [3:0] h, input logic [3:0] d);
        @(negedge clk);
        check_outputs();
        req = r; req_rd_wr = rw; req_addr = ad;
        snoop_ack = k; snoop_hit = h; snoop_dirty = d;
        @(posedge clk);
        model_edge(r, rw, ad, k, h, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; snoop_ack = '0; snoop_hit = '0; snoop_dirty = '0;
        #1;
        check("rst_gnt", gnt, 4'b0);
        check("rst_valid", bus_valid, 1'b0);
        check("rst_id", bus_proc_id, 2'd0);
        check("rst_rw", bus_rd_wr, 1'b0);
        check("rst_addr", bus_addr, '0);
        check("rst_done", done, 1'b0);
        check("rst_shared", resp_shared, 1'b0);
        check("rst_dirty", resp_dirty, 1'b0);
`ifdef SNOOP_TIMEOUT_EN
        check("rst_terr", timeout_err, 1'b0);
`endif
        model_reset();
        prev_valid = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int order[5];
        logic [3:0] r, k;
        order = '{0, 1, 2, 3, 0};
        model_reset();
        do_reset();
        // Core 1 write to 0x3C, other cores ack together
        cyc(4'b0010, 4'b0010, 32'h0000_3C00, 4'b0, 4'b0, 4'b0);
        #1;
        check("r36_gnt", gnt, 4'b0010);
        check("r36_id", bus_proc_id, 2'd1);
        check("r36_addr", bus_addr, 8'h3C);
        check("r36_rw", bus_rd_wr, 1'b1);
        cyc(4'b0, 4'b0, '0, 4'b1101, 4'b0, 4'b0);
        #1 check("r36_done", done, 1'b1);
        cyc(4'b0, 4'b0, '0, 4'b0, 4'b0, 4'b0);
        // Core 2 requests then drops req; staggered acks, core 0 holds it Modified
        cyc(4'b0100, 4'b0, 32'h5500_0000, 4'b0, 4'b0, 4'b0);
        #1 check("r38_gnt", gnt, 4'b0100);
        cyc(4'b0, 4'b0, '0, 4'b0001, 4'b0001, 4'b0001);
        cyc(4'b0, 4'b0, '0, 4'b0, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, '0, 4'b0010, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, '0, 4'b0, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, '0, 4'b1000, 4'b0, 4'b0);
        #1;
        check("r38_done", done, 1'b1);
        check("r38_shared", resp_shared, 1'b1);
        check("r38_dirty", resp_dirty, 1'b1);
        cyc(4'b0, 4'b0, '0, 4'b0, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, '0, 4'b0, 4'b0, 4'b0);
        // Core 0 wins; core 3 acks twice, core 1 never acks, then reset mid-SNOOP
        cyc(4'b0001, 4'b0, 32'h0000_0077, 4'b0, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, '0, 4'b1000, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, '0, 4'b0100, 4'b0, 4'b0);
        cyc(4'b0, 4'b0, '0, 4'b1000, 4'b0, 4'b0);
        for (int i = 0; i < 9; i++) cyc(4'b0, 4'b0, '0, 4'b0, 4'b0, 4'b0);
        #1 check("r39_pending", bus_valid, 1'b1);
        do_reset();
        // All cores request continuously: grants rotate from core 0
        seen.delete();
        for (int i = 0; i < 15; i++) cyc(4'b1111, 4'b0101, 32'h4433_2211, 4'b1111, 4'b0, 4'b0);
        check("r37_count", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) check("r37_order", seen[i], order[i]);
        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            r = ($urandom_range(0, 9) < 3) ? 4'b0 : 4'($urandom);
            k = 4'($urandom) & 4'($urandom);
            cyc(r, 4'($urandom), 32'($urandom), k, 4'($urandom), 4'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
